regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised general-purpose register file with an integrated per-register pending-write scoreboard for the pipelined datapath. It provides two combinational read ports with write-first bypass and one synchronous write port, and register 0 is hardwired to zero. Per-register counters track in-flight producers claimed at issue and retired at writeback, so the issue stage can detect RAW hazards. A flush input clears all pending state after a pipeline squash.

## Interface
- XLEN, 64, data width of each register and of the read/write data ports.
- AW, 5, register address width; the block holds NREGS = 2**AW registers.
- CW, 2, pending-counter width; each register allows at most 2**CW-1 outstanding claims.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- read_register_1  input  AW  read port 1 address.
- read_register_2  input  AW  read port 2 address.
- read_data_1  output  XLEN  read port 1 data (combinational).
- read_data_2  output  XLEN  read port 2 data (combinational).
- read_busy_1  output  1  high when the register at read_register_1 has at least one pending claim.
- read_busy_2  output  1  same as read_busy_1, for port 2.
- reg_write  input  1  write enable (writeback/retire).
- write_register  input  AW  write address.
- write_data  input  XLEN  write data.
- claim_en  input  1  issue stage claims a destination register.
- claim_register  input  AW  claimed register address.
- claim_ready  output  1  high when a claim on claim_register would be accepted this cycle.
- flush  input  1  clears all pending counters.

## Operation
- Storage: NREGS x XLEN data registers and NREGS x CW pending counters cnt[i].
- Register 0 reads as 0 at all times. Writes to it are discarded. Claims on it are accepted but have no effect, so cnt[0] stays 0.
- Read: read_data_n = 0 if the address is 0.
- Otherwise read_data_n = write_data if reg_write and write_register equals the address (bypass).
- Otherwise read_data_n = the stored value.
- read_busy_n = (cnt[addr] != 0), evaluated on the pre-edge counter value. A write in the same cycle does not clear busy combinationally.
- Write: on the rising edge, if reg_write and write_register != 0, store write_data.
- A write always updates data, whether or not the register is claimed.
- Counter update per register i on the rising edge:
  - claim = claim_en and claim_register == i and i != 0 and claim_ready.
  - retire = reg_write and write_register == i and cnt[i] != 0.
  - claim only: cnt + 1. Retire only: cnt - 1. Both: unchanged. Neither: unchanged.
- Saturation:
  - claim_ready = 0 when cnt[claim_register] == 2**CW-1 and no retire hits that register this cycle. Otherwise claim_ready = 1.
  - A claim presented while claim_ready = 0 is dropped; the requester must hold and retry.
- Underflow: a write to a register with cnt == 0 updates data only; the counter stays 0.
- Flush: on the rising edge all cnt are set to 0. Flush overrides any claim or retire in the same cycle. A same-cycle data write still occurs.
- Reset: asynchronously clears all data registers and all cnt to 0.
  - While rst is high, writes and claims are ignored, the bypass is suppressed, and claim_ready = 0.

## Timing
- Read data and busy: combinational, zero latency from address.
- Write data: visible through the bypass in the same cycle and from storage from the next cycle.
- Claim: busy is visible on read ports the cycle after the accepting edge.
- Retire: busy clears the cycle after the edge on which cnt reaches 0.
- Reset values: read_data_1/2 = 0, read_busy_1/2 = 0, claim_ready = 0 while rst is asserted and 1 after release.
- Reset asserted mid-operation clears state immediately, without waiting for clk. The first edge after deassertion behaves normally.

## Test plan
- Reset then read all 32 registers: every read_data = 0, every busy = 0, claim_ready = 1.
- Write 64'hDEAD_BEEF_0000_0001 to register 5 while reading register 5 on port 1 in the same cycle: read_data_1 shows the new value via bypass. Write to register 0: register 0 still reads 0.
- Claim register 7 three times (CW=2): busy_1 is high after the first claim and claim_ready = 0 after the third. A fourth claim is dropped. Three writes to register 7 are needed before busy_1 drops, one cycle after the third write.
- Claim and write register 9 in the same cycle with cnt = 1: cnt stays 1, busy stays high, and the data is updated.
- Claim registers 3, 4 and 5, then assert flush together with a claim on register 6: all busy bits read 0 next cycle, including register 6.
- Claim register 2 and write register 8, then assert rst asynchronously between edges: outputs go to 0 immediately, and after release register 8 reads 0 and register 2 is not busy.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   General-purpose register file with a per-register pending-write scoreboard.
//   Register 0 is hardwired to zero. There are two combinational read ports
//   with write-first bypass and one synchronous write port. Each register has a
//   saturating claim counter: the issue stage increments it when it claims a
//   destination, and writeback decrements it. The read ports report whether
//   the addressed register still has producers in flight. A flush clears every
//   counter.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   read_register_1/2             read addresses
//   read_data_1/2                 combinational read data (bypassed)
//   read_busy_1/2                 addressed register has pending claims
//   reg_write, write_register,    write/retire port
//   write_data
//   claim_en, claim_register      issue-stage destination claim
//   claim_ready                   a claim on claim_register is accepted now
//   flush                         clear all pending counters
module regfile_scoreboard #(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   read_register_1,
  input  logic [AW-1:0]   read_register_2,
  output logic [XLEN-1:0] read_data_1,
  output logic [XLEN-1:0] read_data_2,
  output logic            read_busy_1,
  output logic            read_busy_2,
  input  logic            reg_write,
  input  logic [AW-1:0]   write_register,
  input  logic [XLEN-1:0] write_data,
  input  logic            claim_en,
  input  logic [AW-1:0]   claim_register,
  output logic            claim_ready,
  input  logic            flush
);

  localparam int NREGS = 2 ** AW;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] regs [NREGS];
  logic [CW-1:0]   cnt  [NREGS];

  logic [NREGS-1:0] claim_vec;
  logic [NREGS-1:0] retire_vec;

  // While rst is high the bypass is suppressed. Storage is already cleared
  // asynchronously, so both read ports return zero.
  always_comb begin
    read_data_1 = '0;
    if (read_register_1 != '0) begin
      if (!rst && reg_write && (write_register == read_register_1))
        read_data_1 = write_data;
      else
        read_data_1 = regs[read_register_1];
    end
  end

  always_comb begin
    read_data_2 = '0;
    if (read_register_2 != '0) begin
      if (!rst && reg_write && (write_register == read_register_2))
        read_data_2 = write_data;
      else
        read_data_2 = regs[read_register_2];
    end
  end

  // Busy reflects the pre-edge count only; a same-cycle retire does not
  // clear it combinationally.
  assign read_busy_1 = (cnt[read_register_1] != '0);
  assign read_busy_2 = (cnt[read_register_2] != '0);

  // A saturated counter can still take a claim when a retire on the same
  // register frees a slot in the same cycle (the net count is unchanged).
  assign claim_ready = !rst &&
                       !((cnt[claim_register] == CNT_MAX) && !retire_vec[claim_register]);

  always_comb begin
    claim_vec  = '0;
    retire_vec = '0;
    for (int i = 1; i < NREGS; i++) begin
      claim_vec[i]  = claim_en && claim_ready && (claim_register == AW'(i));
      retire_vec[i] = reg_write && (write_register == AW'(i)) && (cnt[i] != '0);
    end
  end

  // Data storage: register 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_write && (write_register != '0)) begin
      regs[write_register] <= write_data;
    end
  end

  // Pending counters: flush wins over any same-cycle claim or retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (claim_vec[i] && !retire_vec[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (retire_vec[i] && !claim_vec[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  localparam int XLEN  = 64;
  localparam int AW    = 5;
  localparam int CW    = 2;
  localparam int NREGS = 32;
  localparam int CMAX  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   read_register_1, read_register_2;
  logic [XLEN-1:0] read_data_1, read_data_2;
  logic            read_busy_1, read_busy_2;
  logic            reg_write;
  logic [AW-1:0]   write_register;
  logic [XLEN-1:0] write_data;
  logic            claim_en;
  logic [AW-1:0]   claim_register;
  logic            claim_ready;
  logic            flush;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .read_register_1(read_register_1), .read_register_2(read_register_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .read_busy_1(read_busy_1), .read_busy_2(read_busy_2),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .claim_en(claim_en), .claim_register(claim_register), .claim_ready(claim_ready),
    .flush(flush)
  );

  // Reference model: plain values and outstanding-claim counts per register.
  logic [XLEN-1:0] mregs [NREGS];
  int              mcnt  [NREGS];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [XLEN-1:0] got,
                           input logic [XLEN-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int a);
    if (a == 0) return '0;
    if (!rst && reg_write && int'(write_register) == a) return write_data;
    return mregs[a];
  endfunction

  function automatic logic exp_ready();
    int c;
    c = int'(claim_register);
    if (rst) return 1'b0;
    if (mcnt[c] == CMAX && !(reg_write && int'(write_register) == c && mcnt[c] > 0))
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mregs[i] = '0;
      mcnt[i]  = 0;
    end
  endtask

  task automatic model_edge();
    int  c, r;
    logic rdy;
    rdy = exp_ready();
    if (flush) begin
      for (int i = 0; i < NREGS; i++) mcnt[i] = 0;
    end else begin
      c = -1;
      r = -1;
      if (claim_en && claim_register != 0 && rdy) c = int'(claim_register);
      if (reg_write && mcnt[write_register] > 0) r = int'(write_register);
      if (c != r) begin
        if (c >= 0) mcnt[c] = mcnt[c] + 1;
        if (r >= 0) mcnt[r] = mcnt[r] - 1;
      end
    end
    if (reg_write && write_register != 0) mregs[write_register] = write_data;
  endtask

  task automatic check_outputs();
    check_val("read_data_1", read_data_1, exp_rd(int'(read_register_1)));
    check_val("read_data_2", read_data_2, exp_rd(int'(read_register_2)));
    check_val("read_busy_1", 64'(read_busy_1), 64'(mcnt[read_register_1] != 0));
    check_val("read_busy_2", 64'(read_busy_2), 64'(mcnt[read_register_2] != 0));
    check_val("claim_ready", 64'(claim_ready), 64'(exp_ready()));
  endtask

  // Called just after a falling edge: drive inputs, then check outputs.
  task automatic drive(input logic we, input int wa, input logic [XLEN-1:0] wd,
                       input logic ce, input int cr, input logic fl,
                       input int r1, input int r2);
    reg_write       = we;
    write_register  = AW'(wa);
    write_data      = wd;
    claim_en        = ce;
    claim_register  = AW'(cr);
    flush           = fl;
    read_register_1 = AW'(r1);
    read_register_2 = AW'(r2);
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int r1, input int r2);
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0, r1, r2);
  endtask

  initial begin
    rst = 1'b1;
    reg_write = 1'b0; write_register = '0; write_data = '0;
    claim_en = 1'b0; claim_register = '0; flush = 1'b0;
    read_register_1 = '0; read_register_2 = '0;
    model_reset();
    #1;
    check_val("rst_ready", 64'(claim_ready), 64'd0);
    check_val("rst_rd1", read_data_1, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Every register reads zero and idle after reset.
    for (int i = 0; i < 16; i++) begin
      idle(i, i + 16);
      check_val("post_rst_ready", 64'(claim_ready), 64'd1);
      tick();
    end

    // Bypass on write to register 5; writes to register 0 are discarded.
    drive(1'b1, 5, 64'hDEAD_BEEF_0000_0001, 1'b0, 0, 1'b0, 5, 0);
    check_val("bypass_r5", read_data_1, 64'hDEAD_BEEF_0000_0001);
    tick();
    drive(1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0, 0, 5);
    check_val("r0_bypass", read_data_1, 64'd0);
    tick();
    idle(0, 5);
    check_val("r0_zero", read_data_1, 64'd0);
    check_val("r5_stored", read_data_2, 64'hDEAD_BEEF_0000_0001);

    // Saturating claims on register 7.
    drive(1'b0, 0, '0, 1'b1, 7, 1'b0, 7, 0);
    tick();
    drive(1'b0, 0, '0, 1'b1, 7, 1'b0, 7, 0);
    check_val("r7_busy_after_1", 64'(read_busy_1), 64'd1);
    tick();
    drive(1'b0, 0, '0, 1'b1, 7, 1'b0, 7, 0);
    tick();
    drive(1'b0, 0, '0, 1'b1, 7, 1'b0, 7, 0);
    check_val("r7_sat_ready", 64'(claim_ready), 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 7, 64'(100 + k), 1'b0, 0, 1'b0, 7, 0);
      check_val("r7_busy_during_write", 64'(read_busy_1), 64'd1);
      tick();
    end
    idle(7, 0);
    check_val("r7_busy_cleared", 64'(read_busy_1), 64'd0);
    check_val("r7_data", read_data_1, 64'd102);

    // Claim and retire together on register 9 with one pending claim.
    drive(1'b0, 0, '0, 1'b1, 9, 1'b0, 9, 0);
    tick();
    drive(1'b1, 9, 64'h1234_5678_9ABC_DEF0, 1'b1, 9, 1'b0, 9, 0);
    tick();
    idle(9, 0);
    check_val("r9_busy_kept", 64'(read_busy_1), 64'd1);
    check_val("r9_data", read_data_1, 64'h1234_5678_9ABC_DEF0);
    drive(1'b1, 9, 64'd9, 1'b0, 0, 1'b0, 9, 0);
    tick();

    // Flush overrides a same-cycle claim.
    for (int r = 3; r <= 5; r++) begin
      drive(1'b0, 0, '0, 1'b1, r, 1'b0, 0, 0);
      tick();
    end
    drive(1'b0, 0, '0, 1'b1, 6, 1'b1, 3, 4);
    tick();
    idle(3, 6);
    check_val("flush_r3", 64'(read_busy_1), 64'd0);
    check_val("flush_r6", 64'(read_busy_2), 64'd0);
    idle(4, 5);

    // Asynchronous reset between edges.
    drive(1'b0, 0, '0, 1'b1, 2, 1'b0, 0, 0);
    tick();
    drive(1'b1, 8, 64'hCAFE_F00D_0000_0008, 1'b0, 0, 1'b0, 8, 2);
    tick();
    idle(8, 2);
    check_val("pre_rst_r8", read_data_1, 64'hCAFE_F00D_0000_0008);
    check_val("pre_rst_busy2", 64'(read_busy_2), 64'd1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_val("async_rst_rd1", read_data_1, 64'd0);
    check_val("async_rst_busy2", 64'(read_busy_2), 64'd0);
    check_val("async_rst_ready", 64'(claim_ready), 64'd0);
    @(negedge clk);
    drive(1'b1, 8, 64'd55, 1'b1, 2, 1'b0, 8, 2);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(8, 2);
    check_val("post_rst_r8", read_data_1, 64'd0);
    check_val("post_rst_busy2", 64'(read_busy_2), 64'd0);

    // Randomized traffic on a narrow address window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      int r1, r2;
      r1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      r2 = int'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 31) == 0), r1, r2);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
